// File: rtl/line_stream_pkg.sv
// Shared types and width helpers for the line-stream raster path.
//   lss_state_t : source FSM states (IDLE, RUN, STOP)
//   HW(n)       : bit width of a horizontal counter spanning 0..n-1
//   VW(n)       : bit width of a vertical counter spanning 0..n-1 (at least 1)
package line_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } lss_state_t;

  function automatic int HW(input int line_end);
    return (line_end > 1) ? $clog2(line_end) : 1;
  endfunction

  // A one-line frame still needs a 1-bit line index port.
  function automatic int VW(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/raster_timing_cnt.sv
// Horizontal/vertical raster position counters.
//   clk, rst          : clock, asynchronous active-high reset
//   i_en              : advance one slot per cycle
//   i_clr             : synchronous clear of both counters (wins over i_en)
//   o_hcnt            : slot within line, 0..H_TOTAL-1
//   o_vcnt            : line within frame, 0..V_TOTAL-1
//   o_line_last       : current slot is the last of its line
//   o_frame_last      : current slot is the last of the frame
module raster_timing_cnt
  import line_stream_pkg::*;
#(
  parameter int H_TOTAL = 2048,
  parameter int V_TOTAL = 900
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  output logic [HW(H_TOTAL)-1:0] o_hcnt,
  output logic [VW(V_TOTAL)-1:0] o_vcnt,
  output logic                   o_line_last,
  output logic                   o_frame_last
);

  localparam int HW_L = HW(H_TOTAL);
  localparam int VW_L = VW(V_TOTAL);
  localparam logic [HW_L-1:0] H_LAST = HW_L'(H_TOTAL - 1);
  localparam logic [VW_L-1:0] V_LAST = VW_L'(V_TOTAL - 1);

  logic [HW_L-1:0] r_hcnt;
  logic [VW_L-1:0] r_vcnt;
  logic            w_line_last;
  logic            w_frame_last;

  assign w_line_last  = (r_hcnt == H_LAST);
  assign w_frame_last = w_line_last && (r_vcnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_clr) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_en) begin
      if (w_line_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_frame_last ? '0 : r_vcnt + VW_L'(1);
      end else begin
        r_hcnt <= r_hcnt + HW_L'(1);
      end
    end
  end

  assign o_hcnt       = r_hcnt;
  assign o_vcnt       = r_vcnt;
  assign o_line_last  = w_line_last;
  assign o_frame_last = w_frame_last;

endmodule

// File: rtl/line_stream_src.sv
// Raster source for the line-buffer window path. Pops pixels from an
// upstream valid/ready source into fixed-timing slots: SCREENWIDTH active
// slots then blanking up to LINE_END cycles per line, SCREENHEIGHT lines.
// Horizontal timing never stalls; a missing pixel loses its slot.
//   clk, rst       : clock, asynchronous active-high reset
//   tp_i           : test-pattern select (only with LINE_STREAM_TEST_PATTERN_EN)
//   en_i           : stream enable; dropping it finishes the current frame
//   s_data_i/s_valid_i/s_ready_o : upstream pixel handshake (ready is combinational)
//   data_o, dv_o   : registered pixel and valid
//   line_end_o     : registered pulse on the last slot of each line
//   frame_start_o  : registered pulse on slot 0 of line 0
//   underflow_o    : sticky, active slot without upstream data
//   line_cnt_o     : current line index
// Optional feature macro: LINE_STREAM_TEST_PATTERN_EN adds tp_i, which
// replaces upstream data with hcnt ^ vcnt on every active slot.
module line_stream_src
  import line_stream_pkg::*;
#(
  parameter int COLORDEPTH   = 8,
  parameter int SCREENWIDTH  = 1600,
  parameter int LINE_END     = 2048,
  parameter int SCREENHEIGHT = 900
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef LINE_STREAM_TEST_PATTERN_EN
  input  logic                        tp_i,
`endif
  input  logic                        en_i,
  input  logic [COLORDEPTH-1:0]       s_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  output logic [COLORDEPTH-1:0]       data_o,
  output logic                        dv_o,
  output logic                        line_end_o,
  output logic                        frame_start_o,
  output logic                        underflow_o,
  output logic [VW(SCREENHEIGHT)-1:0] line_cnt_o
);

  localparam int HW_L = HW(LINE_END);
  localparam int VW_L = VW(SCREENHEIGHT);

  if (SCREENWIDTH <= 0 || SCREENWIDTH >= LINE_END || SCREENHEIGHT < 1) begin : g_bad_params
    $error("line_stream_src: need 0 < SCREENWIDTH < LINE_END and SCREENHEIGHT >= 1");
  end

  localparam logic [HW_L-1:0] SW_L = HW_L'(SCREENWIDTH);

  lss_state_t      r_state;
  lss_state_t      w_state_nxt;
  logic            w_cnt_clr;
  logic            w_running;
  logic            w_active;
  logic            w_tp;
  logic [HW_L-1:0] w_hcnt;
  logic [VW_L-1:0] w_vcnt;
  logic            w_line_last;
  logic            w_frame_last;

  logic [COLORDEPTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_line_end;
  logic                  r_frame_start;
  logic                  r_underflow;

  raster_timing_cnt #(
    .H_TOTAL (LINE_END),
    .V_TOTAL (SCREENHEIGHT)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_running),
    .i_clr        (w_cnt_clr),
    .o_hcnt       (w_hcnt),
    .o_vcnt       (w_vcnt),
    .o_line_last  (w_line_last),
    .o_frame_last (w_frame_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: if (en_i) w_state_nxt = RUN;
      RUN:  if (!en_i) w_state_nxt = STOP;
      STOP: begin
        if (en_i) begin
          w_state_nxt = RUN;
        end else if (w_frame_last) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_running = (r_state != IDLE);
  assign w_active  = w_running && (w_hcnt < SW_L);

`ifdef LINE_STREAM_TEST_PATTERN_EN
  logic [COLORDEPTH-1:0] w_pattern;
  assign w_tp      = tp_i;
  assign w_pattern = COLORDEPTH'(w_hcnt) ^ COLORDEPTH'(w_vcnt);
`else
  assign w_tp = 1'b0;
`endif

  // Pattern mode owns the slot, so the upstream is never popped.
  assign s_ready_o = w_active && !w_tp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data        <= '0;
      r_dv          <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_dv          <= 1'b0;
      r_line_end    <= w_running && w_line_last;
      r_frame_start <= w_running && (w_hcnt == '0) && (w_vcnt == '0);
      if (w_active) begin
`ifdef LINE_STREAM_TEST_PATTERN_EN
        if (w_tp) begin
          r_dv   <= 1'b1;
          r_data <= w_pattern;
        end else
`endif
        if (s_valid_i) begin
          r_dv   <= 1'b1;
          r_data <= s_data_i;
        end else if (!w_tp) begin
          // Slot is lost; data_o keeps the previous pixel.
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign data_o        = r_data;
  assign dv_o          = r_dv;
  assign line_end_o    = r_line_end;
  assign frame_start_o = r_frame_start;
  assign underflow_o   = r_underflow;
  assign line_cnt_o    = w_vcnt;

endmodule
